alu_station: RTL

- ALU reservation station plus execute stage. Sits directly upstream of the common data bus and feeds its ALU input (valid, tag, result).
- Holds up to RS_N dispatched ALU ops. Snoops the CDB broadcast for pending operand tags.
- Issues at most one ready op per cycle to an integrated single-cycle ALU. Presents the result registered, as a one-cycle pulse.

---
 rtl/alu_station.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_station.sv
// ALU reservation station with integrated single-cycle execute stage.
// Snoops the CDB for pending operand tags and issues the lowest ready entry each cycle.
module alu_station #(
  parameter int                 DATA_W  = 32,
  parameter int                 TAG_W   = 5,
  parameter logic [TAG_W-1:0]   NO_LOCK = 5'b10000,
  parameter int                 RS_N    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [3:0]        disp_op,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic [DATA_W-1:0] disp_vk,
  input  logic [TAG_W-1:0]  disp_qk,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic [TAG_W-1:0]  cdb_index,
  input  logic [DATA_W-1:0] cdb_result,
  output logic              alu_out_valid,
  output logic [TAG_W-1:0]  alu_out_index,
  output logic [DATA_W-1:0] alu_out_result
);

  localparam int IDX_W = (RS_N > 1) ? $clog2(RS_N) : 1;

  logic [RS_N-1:0]   busy;
  logic [3:0]        op_q   [RS_N];
  logic [DATA_W-1:0] vj_q   [RS_N];
  logic [TAG_W-1:0]  qj_q   [RS_N];
  logic [DATA_W-1:0] vk_q   [RS_N];
  logic [TAG_W-1:0]  qk_q   [RS_N];
  logic [TAG_W-1:0]  dest_q [RS_N];

  logic [RS_N-1:0]   ready;
  logic              full;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              issue_any;
  logic [IDX_W-1:0]  issue_idx;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [4:0]        shamt;
  logic [DATA_W-1:0] alu_res;

  // Free-slot and issue selection both look only at registered state.
  always_comb begin
    full       = 1'b1;
    free_found = 1'b0;
    free_idx   = '0;
    issue_any  = 1'b0;
    issue_idx  = '0;
    for (int i = 0; i < RS_N; i++) begin
      ready[i] = busy[i] && (qj_q[i] == NO_LOCK) && (qk_q[i] == NO_LOCK);
      full     = full && busy[i];
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (ready[i] && !issue_any) begin
        issue_any = 1'b1;
        issue_idx = IDX_W'(i);
      end
    end
  end

  assign disp_ready = !full;

  always_comb begin
    op_a  = vj_q[issue_idx];
    op_b  = vk_q[issue_idx];
    shamt = op_b[4:0];
    case (op_q[issue_idx])
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << shamt;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
      4'd8:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9:    alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy           <= '0;
      alu_out_valid  <= 1'b0;
      alu_out_index  <= NO_LOCK;
      alu_out_result <= '0;
    end else begin
      for (int i = 0; i < RS_N; i++) begin
        if (busy[i] && (cdb_index != NO_LOCK)) begin
          if (qj_q[i] == cdb_index) begin
            vj_q[i] <= cdb_result;
            qj_q[i] <= NO_LOCK;
          end
          if (qk_q[i] == cdb_index) begin
            vk_q[i] <= cdb_result;
            qk_q[i] <= NO_LOCK;
          end
        end
      end

      if (issue_any) begin
        busy[issue_idx] <= 1'b0;
        alu_out_valid   <= 1'b1;
        alu_out_index   <= dest_q[issue_idx];
        alu_out_result  <= alu_res;
      end else begin
        alu_out_valid  <= 1'b0;
        alu_out_index  <= NO_LOCK;
        alu_out_result <= '0;
      end

      // The free slot is never the issuing one, so both writes can coexist.
      if (disp_valid && !full) begin
        busy[free_idx]   <= 1'b1;
        op_q[free_idx]   <= disp_op;
        dest_q[free_idx] <= disp_dest;
        if ((disp_qj != NO_LOCK) && (disp_qj == cdb_index)) begin
          vj_q[free_idx] <= cdb_result;
          qj_q[free_idx] <= NO_LOCK;
        end else begin
          vj_q[free_idx] <= disp_vj;
          qj_q[free_idx] <= disp_qj;
        end
        if ((disp_qk != NO_LOCK) && (disp_qk == cdb_index)) begin
          vk_q[free_idx] <= cdb_result;
          qk_q[free_idx] <= NO_LOCK;
        end else begin
          vk_q[free_idx] <= disp_vk;
          qk_q[free_idx] <= disp_qk;
        end
      end
    end
  end

endmodule
